// File: rtl/grf_mp_pkg.sv
// grf_mp_pkg -- shared definitions for the multi-port general register file.
//   GRF_DW_DEFAULT : default data width
//   GRF_AW_DEFAULT : default address width (depth = 2**AW)
//   REG_ZERO       : hard-wired zero register index
package grf_mp_pkg;

  localparam int GRF_DW_DEFAULT = 32;
  localparam int GRF_AW_DEFAULT = 5;
  localparam int REG_ZERO       = 0;

endpackage

// File: rtl/grf_bypass_mux.sv
// grf_bypass_mux -- read-port data select with same-cycle write bypass.
// Priority: register 0 -> 0, lane 1 hit -> wd1, lane 0 hit -> wd0, else array word.
// Ports:
//   ra_i        read address
//   we0_i/wa0_i/wd0_i  lane 0 (older) write
//   we1_i/wa1_i/wd1_i  lane 1 (younger, wins) write
//   mem_word_i  array contents at ra_i
//   rdata_o     selected read data
module grf_bypass_mux
  import grf_mp_pkg::*;
#(
  parameter int DW = GRF_DW_DEFAULT,
  parameter int AW = GRF_AW_DEFAULT
) (
  input  logic [AW-1:0] ra_i,
  input  logic          we0_i,
  input  logic [AW-1:0] wa0_i,
  input  logic [DW-1:0] wd0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] wa1_i,
  input  logic [DW-1:0] wd1_i,
  input  logic [DW-1:0] mem_word_i,
  output logic [DW-1:0] rdata_o
);

  always_comb begin
    // NOTE: default assigned first so every path drives rdata_o (no latch).
    rdata_o = mem_word_i;
    if (ra_i == AW'(REG_ZERO)) begin
      rdata_o = '0;
    end else if (we1_i && (wa1_i == ra_i)) begin
      rdata_o = wd1_i;
    end else if (we0_i && (wa0_i == ra_i)) begin
      rdata_o = wd0_i;
    end
  end

endmodule

// File: rtl/grf_mp.sv
// grf_mp -- parametrised general register file: two write lanes, NRD bypassed
// read ports, and a per-register pending scoreboard for the hazard unit.
// Optional macro GRF_TRACE_EN: prints one trace line per accepted write.
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   we0/wa0/wd0/wpc0      lane 0 write (older); wpc0 used by trace only
//   we1/wa1/wd1/wpc1      lane 1 write (younger, wins conflicts)
//   ra / rd               packed read addresses / bypassed read data
//   set_en / set_addr     mark a destination register pending
//   rpend                 pending bit of each read address (not bypassed)
//   pend_any              OR of all pending bits
module grf_mp
  import grf_mp_pkg::*;
#(
  parameter int DW  = GRF_DW_DEFAULT,
  parameter int AW  = GRF_AW_DEFAULT,
  parameter int NRD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we0,
  input  logic [AW-1:0]     wa0,
  input  logic [DW-1:0]     wd0,
  input  logic [31:0]       wpc0,
  input  logic              we1,
  input  logic [AW-1:0]     wa1,
  input  logic [DW-1:0]     wd1,
  input  logic [31:0]       wpc1,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*DW-1:0] rd,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  output logic [NRD-1:0]    rpend,
  output logic              pend_any
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;

  // NOTE: the array is reset because the CPU relies on every register
  // reading 0 after reset; this keeps it out of block RAM on purpose.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else begin
      // NOTE: non-blocking writes; on a same-address conflict the lane-1
      // assignment is scheduled last, so the younger instruction's data lands.
      if (we0 && (wa0 != AW'(REG_ZERO))) mem_q[wa0] <= wd0;
      if (we1 && (wa1 != AW'(REG_ZERO))) mem_q[wa1] <= wd1;
    end
  end

  // Retiring writes clear, issue sets; set applied last so a new producer
  // supersedes one retiring in the same cycle.
  always_comb begin
    pend_d = pend_q;
    if (we0)    pend_d[wa0]      = 1'b0;
    if (we1)    pend_d[wa1]      = 1'b0;
    if (set_en) pend_d[set_addr] = 1'b1;
    pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign pend_any = |pend_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra_i;
    logic [DW-1:0] byp_data;

    assign ra_i = ra[i*AW +: AW];

    grf_bypass_mux #(
      .DW(DW),
      .AW(AW)
    ) u_mux (
      .ra_i      (ra_i),
      .we0_i     (we0),
      .wa0_i     (wa0),
      .wd0_i     (wd0),
      .we1_i     (we1),
      .wa1_i     (wa1),
      .wd1_i     (wd1),
      .mem_word_i(mem_q[ra_i]),
      .rdata_o   (byp_data)
    );

    // The bypass would otherwise forward write data while reset is held.
    assign rd[i*DW +: DW] = reset ? byp_data : '0;
    assign rpend[i]       = reset & pend_q[ra_i];
  end

`ifdef GRF_TRACE_EN
  always @(posedge clk) begin
    if (reset) begin
      if (we0) $display("%d@%h: $%d <= %h", $time, wpc0, wa0, wd0);
      if (we1) $display("%d@%h: $%d <= %h", $time, wpc1, wa1, wd1);
    end
  end
`else
  logic unused_wpc;
  assign unused_wpc = ^{wpc0, wpc1};
`endif

endmodule

// File: tb/tb_grf_mp.sv
// tb_grf_mp -- self-checking bench for grf_mp. Instance A uses the default
// configuration (DW=32, AW=5, NRD=2); instance B uses DW=16, AW=3, NRD=4.
// A plain array/flag model predicts every read and pending output.
module tb_grf_mp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A signals
  logic        a_we0, a_we1, a_set_en, a_pend_any;
  logic [4:0]  a_wa0, a_wa1, a_set_addr;
  logic [31:0] a_wd0, a_wd1, a_wpc0, a_wpc1;
  logic [9:0]  a_ra;
  logic [63:0] a_rd;
  logic [1:0]  a_rpend;

  // Instance B signals
  logic        b_we0, b_we1, b_set_en, b_pend_any;
  logic [2:0]  b_wa0, b_wa1, b_set_addr;
  logic [15:0] b_wd0, b_wd1;
  logic [31:0] b_wpc0, b_wpc1;
  logic [11:0] b_ra;
  logic [63:0] b_rd;
  logic [3:0]  b_rpend;

  grf_mp u_a (
    .clk(clk), .reset(rst_n),
    .we0(a_we0), .wa0(a_wa0), .wd0(a_wd0), .wpc0(a_wpc0),
    .we1(a_we1), .wa1(a_wa1), .wd1(a_wd1), .wpc1(a_wpc1),
    .ra(a_ra), .rd(a_rd), .set_en(a_set_en), .set_addr(a_set_addr),
    .rpend(a_rpend), .pend_any(a_pend_any)
  );

  grf_mp #(.DW(16), .AW(3), .NRD(4)) u_b (
    .clk(clk), .reset(rst_n),
    .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .wpc0(b_wpc0),
    .we1(b_we1), .wa1(b_wa1), .wd1(b_wd1), .wpc1(b_wpc1),
    .ra(b_ra), .rd(b_rd), .set_en(b_set_en), .set_addr(b_set_addr),
    .rpend(b_rpend), .pend_any(b_pend_any)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem  [2][32];
  bit          m_pend [2][32];

  task automatic m_clear();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++) begin
        m_mem[k][r]  = '0;
        m_pend[k][r] = 1'b0;
      end
  endtask

  function automatic logic [31:0] m_read(int k, int a, logic we0, int wa0, logic [31:0] wd0,
                                         logic we1, int wa1, logic [31:0] wd1);
    if (a == 0) return 32'h0;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return m_mem[k][a];
  endfunction

  function automatic bit m_any(int k);
    for (int r = 0; r < 32; r++) if (m_pend[k][r]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_step(int k, logic we0, int wa0, logic [31:0] wd0,
                        logic we1, int wa1, logic [31:0] wd1, logic se, int sa);
    if (we0 && wa0 != 0) m_mem[k][wa0] = wd0;
    if (we1 && wa1 != 0) m_mem[k][wa1] = wd1;
    if (we0) m_pend[k][wa0] = 1'b0;
    if (we1) m_pend[k][wa1] = 1'b0;
    if (se && sa != 0) m_pend[k][sa] = 1'b1;
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      m_step(0, a_we0, int'(a_wa0), a_wd0, a_we1, int'(a_wa1), a_wd1, a_set_en, int'(a_set_addr));
      m_step(1, b_we0, int'(b_wa0), {16'h0, b_wd0}, b_we1, int'(b_wa1), {16'h0, b_wd1},
             b_set_en, int'(b_set_addr));
    end
  end

  always @(negedge rst_n) m_clear();

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [31:0] exp;
    for (int i = 0; i < 2; i++) begin
      exp = rst_n ? m_read(0, int'(a_ra[i*5 +: 5]), a_we0, int'(a_wa0), a_wd0,
                           a_we1, int'(a_wa1), a_wd1) : 32'h0;
      check($sformatf("a_rd%0d", i), 64'(a_rd[i*32 +: 32]), 64'(exp));
      check($sformatf("a_rpend%0d", i), 64'(a_rpend[i]),
            64'(rst_n && m_pend[0][int'(a_ra[i*5 +: 5])]));
    end
    for (int i = 0; i < 4; i++) begin
      exp = rst_n ? m_read(1, int'(b_ra[i*3 +: 3]), b_we0, int'(b_wa0), {16'h0, b_wd0},
                           b_we1, int'(b_wa1), {16'h0, b_wd1}) : 32'h0;
      check($sformatf("b_rd%0d", i), 64'(b_rd[i*16 +: 16]), 64'(exp[15:0]));
      check($sformatf("b_rpend%0d", i), 64'(b_rpend[i]),
            64'(rst_n && m_pend[1][int'(b_ra[i*3 +: 3])]));
    end
    check("a_pend_any", 64'(a_pend_any), 64'(rst_n && m_any(0)));
    check("b_pend_any", 64'(b_pend_any), 64'(rst_n && m_any(1)));
  end

  // ---------------- stimulus ----------------
  task automatic a_idle();
    a_we0 = 0; a_wa0 = '0; a_wd0 = '0; a_wpc0 = '0;
    a_we1 = 0; a_wa1 = '0; a_wd1 = '0; a_wpc1 = '0;
    a_set_en = 0; a_set_addr = '0; a_ra = '0;
  endtask

  task automatic b_idle();
    b_we0 = 0; b_wa0 = '0; b_wd0 = '0; b_wpc0 = '0;
    b_we1 = 0; b_wa1 = '0; b_wd1 = '0; b_wpc1 = '0;
    b_set_en = 0; b_set_addr = '0; b_ra = '0;
  endtask

  task automatic randomize_inputs();
    a_we0 = 1'($urandom_range(0, 1));
    a_we1 = 1'($urandom_range(0, 1));
    a_wa0 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    a_wa1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    a_wd0 = $urandom; a_wd1 = $urandom;
    a_wpc0 = 32'h0040_0000 + ($urandom_range(0, 255) << 2);
    a_wpc1 = a_wpc0 + 32'd4;
    a_set_en = ($urandom_range(0, 9) < 3);
    a_set_addr = 5'($urandom_range(0, 7));
    for (int i = 0; i < 2; i++)
      a_ra[i*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
    b_we0 = 1'($urandom_range(0, 1));
    b_we1 = 1'($urandom_range(0, 1));
    b_wa0 = 3'($urandom); b_wa1 = 3'($urandom);
    b_wd0 = 16'($urandom); b_wd1 = 16'($urandom);
    b_wpc0 = $urandom; b_wpc1 = $urandom;
    b_set_en = ($urandom_range(0, 9) < 3);
    b_set_addr = 3'($urandom);
    for (int i = 0; i < 4; i++) b_ra[i*3 +: 3] = 3'($urandom);
  endtask

  initial begin
    m_clear();
    rst_n = 1'b0;
    a_idle();
    b_idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd0", 64'(a_rd[31:0]), 64'h0);
    check("reset_pend_any", 64'(a_pend_any), 64'h0);
    rst_n = 1'b1;

    // same-cycle bypass, then stored value
    @(posedge clk); #1;
    a_idle(); a_we0 = 1; a_wa0 = 5; a_wd0 = 32'hDEADBEEF; a_ra[4:0] = 5;
    #3 check("bypass_same_cycle", 64'(a_rd[31:0]), 64'hDEADBEEF);
    @(posedge clk); #1;
    a_we0 = 0;
    #3 check("bypass_stored", 64'(a_rd[31:0]), 64'hDEADBEEF);

    // dual-lane conflict on $8
    @(posedge clk); #1;
    a_idle(); a_we0 = 1; a_wa0 = 8; a_wd0 = 32'h11; a_we1 = 1; a_wa1 = 8; a_wd1 = 32'h22;
    a_ra = {5'd8, 5'd8};
    #3 check("conflict_same_cycle", 64'(a_rd[63:32]), 64'h22);
    @(posedge clk); #1;
    a_idle(); a_ra[4:0] = 8;
    #3 check("conflict_stored", 64'(a_rd[31:0]), 64'h22);

    // zero register: write and set dropped
    @(posedge clk); #1;
    a_idle(); a_we1 = 1; a_wa1 = 0; a_wd1 = 32'hFFFFFFFF; a_set_en = 1; a_set_addr = 0;
    #3 check("zero_reg_read", 64'(a_rd[31:0]), 64'h0);
    @(posedge clk); #1;
    a_idle();
    #3 check("zero_reg_not_pending", 64'(a_pend_any), 64'h0);

    // scoreboard: set, set+clear, clear
    @(posedge clk); #1;
    a_idle(); a_set_en = 1; a_set_addr = 3; a_ra[9:5] = 3;
    #3 check("sb_not_bypassed", 64'(a_rpend[1]), 64'h0);
    @(posedge clk); #1;
    a_idle(); a_we0 = 1; a_wa0 = 3; a_wd0 = 32'h33; a_set_en = 1; a_set_addr = 3; a_ra[9:5] = 3;
    #3 check("sb_set", 64'(a_rpend[1]), 64'h1);
    @(posedge clk); #1;
    a_idle(); a_we1 = 1; a_wa1 = 3; a_wd1 = 32'h34; a_ra[9:5] = 3;
    #3 check("sb_set_beats_clear", 64'(a_rpend[1]), 64'h1);
    @(posedge clk); #1;
    a_idle(); a_ra[9:5] = 3; a_set_en = 1; a_set_addr = 9;
    #3 check("sb_cleared", 64'(a_rpend[1]), 64'h0);

    // asynchronous reset mid-cycle
    @(posedge clk); #1;
    a_idle(); a_we0 = 1; a_wa0 = 9; a_wd0 = 32'h99; a_ra = {5'd9, 5'd5};
    #1 check("pre_reset_pend", 64'(a_rpend[1]), 64'h1);
    #1 rst_n = 1'b0;
    #1 begin
      check("async_reset_rd", a_rd, 64'h0);
      check("async_reset_rpend", 64'(a_rpend), 64'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_idle(); a_ra[4:0] = 5;
    #3 check("post_reset_r5", 64'(a_rd[31:0]), 64'h0);

    // randomized phase on both instances
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
      randomize_inputs();
      if (n == 700) begin
        #2 rst_n = 1'b0;
        #1 check("rand_async_reset_b", b_rd, 64'h0);
      end
    end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised general register file for the pipelined CPU.
- Successor to the single-write, dual-read GRF.
- Configurable data width, depth, and number of read ports.
- Two write ports: WB (older instruction) and a second write-back lane (younger instruction, higher priority).
- Same-cycle write-to-read bypass, so the decode stage needs no external forwarding from WB.
- Per-register pending scoreboard that the hazard unit uses for stall decisions.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW entries.
- NRD, 2, number of read ports (1..4).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous active-low reset; clears array and scoreboard.
- we0  in  1  write enable, lane 0 (older).
- wa0  in  AW  write address, lane 0.
- wd0  in  DW  write data, lane 0.
- wpc0  in  32  PC of lane-0 writer (trace only).
- we1  in  1  write enable, lane 1 (younger, wins conflicts).
- wa1  in  AW  write address, lane 1.
- wd1  in  DW  write data, lane 1.
- wpc1  in  32  PC of lane-1 writer (trace only).
- ra  in  NRD*AW  packed read addresses; port i = ra[i*AW +: AW].
- rd  out  NRD*DW  packed read data; port i = rd[i*DW +: DW].
- set_en  in  1  mark a destination register pending (issue).
- set_addr  in  AW  register to mark pending.
- rpend  out  NRD  rpend[i] = pending bit of ra port i.
- pend_any  out  1  OR of all pending bits.

Behaviour:
- Reset (reset=0, asynchronous): all entries become 0 and all pending bits clear immediately.
  - rd reads 0 and rpend reads 0 while reset is held.
  - Writes and sets are ignored during reset.
  - After reset deasserts, normal operation resumes on the next rising edge.
- Register 0:
  - Always reads 0.
  - Writes to address 0 are dropped.
  - Never pending; set_addr=0 is ignored.
- Writes (posedge): if weK and waK!=0, mem[waK] <= wdK.
  - If we0 and we1 hit the same nonzero address, lane 1's data is stored.
- Reads are combinational with bypass. For each port i, in priority order:
  - ra=0 -> 0;
  - else we1 and wa1==ra -> wd1;
  - else we0 and wa0==ra -> wd0;
  - else mem[ra].
  - Zero latency; rd reflects the value the array will hold after this edge.
- Scoreboard (posedge), per entry r!=0:
  - Cleared when (we0 and wa0==r) or (we1 and wa1==r).
  - Set when set_en and set_addr==r.
  - Set has priority over clear in the same cycle, since a new producer supersedes the retiring one.
  - Setting an already-pending register keeps it pending; no counting.
- rpend is combinational from the current pending bits and ra. It is not bypassed: a write retiring this cycle still shows pending until the next edge.
- pend_any updates one cycle after the set/clear edge, like the bits themselves.
- No X propagation: all outputs are defined whenever reset=1.

Optional Feature:
- Macro GRF_TRACE_EN.
- When defined: on every posedge with reset=1, print one line per accepted write (including address 0 writes) in the course format "%d@%h: $%d <= %h" ($time, wpcK, waK, wdK).
  - Lane 0 prints before lane 1.
  - A same-address conflict still prints both lines.
- When undefined: no $display; behaviour and ports are otherwise identical, and the wpc0/wpc1 inputs stay present but unused.

Decomposition:
- Shared package: localparam defaults DW/AW and REG_ZERO = 0.
- Natural sub-module: grf_bypass_mux, one per read port. Inputs are the address, both write lanes, and the array word; output is the selected data.
- The scoreboard stays inline as a 2**AW-bit vector.

Test Plan:
- Reset: load several registers, pull reset low mid-cycle -> rd=0 and rpend=0 immediately, without waiting for a clock edge; after release, reading $5 returns 0.
- Basic write/read: we0, wa0=5, wd0=0xDEADBEEF, ra0=5 in the same cycle -> rd0=0xDEADBEEF (bypass); the next cycle with we0=0 still reads 0xDEADBEEF.
- Dual-lane conflict: we0/we1 both to $8 with wd0=0x11, wd1=0x22 -> rd=0x22 in the same cycle and 0x22 after the edge; trace build prints two lines.
- Zero register: we1, wa1=0, wd1=0xFFFFFFFF -> ra=0 reads 0; set_en with set_addr=0 -> pend_any stays 0.
- Scoreboard priority: set $3 -> rpend=1 next cycle. Then a same-cycle write to $3 plus set_en of $3 -> still pending. Then a write-only to $3 -> rpend=0 after the edge.
- Parameter sweep: NRD=4, AW=3, DW=16 -> four independent read ports return the correct bypassed and stored values over random writes, checked against a reference model.
